vrased_multi: RTL and testbench
===============================

VRASED_MULTI -- requirements
Module: vrased_multi

Interface
REQ-001 SHALL have parameter SDATA_BASE, default 16'h0400: secure stack/data region base.
REQ-002 SHALL have parameter SDATA_SIZE, default 16'h0C00: secure data region size (bytes).
REQ-003 SHALL have parameter HMAC_BASE, default 16'h0230: HMAC output region base; HMAC_SIZE, default 16'h0020: its size.
REQ-004 SHALL have parameter SMEM_BASE, default 16'hA000: attestation code base; SMEM_SIZE, default 16'h4000: its size.
REQ-005 SHALL have parameter KMEM_BASE, default 16'h6A00: key region base; KMEM_SIZE, default 16'h0040: its size.
REQ-006 SHALL have parameter RESET_HANDLER, default 16'h0000: PC value that releases the kill state.
REQ-007 SHALL have parameter DMA_CH, default 2: number of monitored DMA masters; legal range 1..4.
REQ-008 SHALL have ports: clk in 1 system clock; reset_n in 1 asynchronous active-low reset.
REQ-009 SHALL have ports: pc in 16 CPU program counter; data_en in 1 CPU data access; data_wr in 1 CPU data write; data_addr in 16 CPU data address; irq in 1 interrupt taken.
REQ-010 SHALL have ports: dma_addr in 16*DMA_CH, channel k at bits [16k+15:16k]; dma_en in DMA_CH per-channel access enable.
REQ-011 SHALL have port reset out 1: MCU reset request.
REQ-012 SHALL have ports (macro-gated, REQ-030): viol_cause out 8 sticky cause bits; viol_count out 8 kill-entry count.

Function
REQ-013 Region membership SHALL be inclusive [BASE, BASE+SIZE-1], computed in 17 bits so no wrap aliasing; LAST = SMEM_BASE+SMEM_SIZE-2.
REQ-014 FSM states SHALL be RUN, ATTEST, KILL; pc_q SHALL register pc every cycle.
REQ-015 RUN->ATTEST when pc in SMEM and pc==SMEM_BASE; pc in SMEM, pc!=SMEM_BASE -> cause bit0 ENTRY.
REQ-016 ATTEST->RUN when pc leaves SMEM and pc_q==LAST; leaving with pc_q!=LAST -> cause bit1 EXIT.
REQ-017 Cause bit2 KEY: data_en and data_addr in KMEM and pc not in SMEM.
REQ-018 Cause bit3 IRQ: irq while state ATTEST and pc in SMEM.
REQ-019 Cause bit4 XSTACK: in RUN, data_en to SDATA; in ATTEST, data_wr to address outside SDATA and outside HMAC.
REQ-020 Cause bit5 DMA_KEY: any channel dma_en with address in KMEM, any state but KILL.
REQ-021 Cause bit6 DMA_SMEM: any channel dma_en while state ATTEST.
REQ-022 Cause bit7 DMA_SDATA: any channel dma_en with address in SDATA.
REQ-023 Any cause bit set in RUN or ATTEST SHALL move FSM to KILL next edge, overriding REQ-015/016 transitions.
REQ-024 reset SHALL be registered: high exactly while state==KILL (one-cycle latency after violation cycle).
REQ-025 KILL->RUN when pc==RESET_HANDLER sampled in KILL; causes ignored while in KILL.
REQ-026 Simultaneous causes SHALL all be logged in the same cycle; channels evaluated independently, no priority.

Reset
REQ-027 reset_n low SHALL asynchronously force state RUN, pc_q 16'h0000, reset 0, viol_cause 8'h00, viol_count 8'h00.
REQ-028 Deassertion mid-attestation SHALL restart in RUN; a following pc inside SMEM other than SMEM_BASE is ENTRY.
REQ-029 Only reset_n SHALL clear viol_cause/viol_count; KILL exit does not.

Configuration
REQ-030 Macro VRASED_CAUSE_LOG_EN defined: viol_cause ORs in all cause bits on each RUN/ATTEST->KILL entry; viol_count increments per entry, saturates at 8'hFF.
REQ-031 Macro undefined: viol_cause, viol_count ports and registers absent; reset behaviour identical.

Verification
REQ-032 pc 16'h9FFE->16'hA000 ... ->16'hDFFE->16'h0100, no other activity -> reset stays 0, states RUN->ATTEST->RUN.
REQ-033 pc jumps 16'h0100->16'hA010 -> reset 1 next cycle, viol_cause 8'h01; pc=16'h0000 -> reset 0 following cycle.
REQ-034 pc 16'h0200, data_en=1, data_addr 16'h6A10 with DMA_CH=2, dma_en=2'b10, ch1 addr 16'h6A00 -> viol_cause 8'h24, viol_count 1.
REQ-035 In ATTEST, irq=1 and data_wr to 16'h2000 same cycle -> viol_cause 8'h18, reset next cycle; further violations during KILL leave viol_count 1.
REQ-036 Force 256 kill/release cycles -> viol_count holds 8'hFF; reset_n pulse low mid-KILL -> reset 0 immediately, all logs 0.

Source files
------------

// File: rtl/vrased_multi.sv
// rtl/vrased_multi.sv - VRASED hardware monitor with multi-channel DMA checks and reset request
// Optional sticky cause/count logging enabled by defining VRASED_CAUSE_LOG_EN.
module vrased_multi #(
    parameter logic [15:0] SDATA_BASE    = 16'h0400,
    parameter logic [15:0] SDATA_SIZE    = 16'h0C00,
    parameter logic [15:0] HMAC_BASE     = 16'h0230,
    parameter logic [15:0] HMAC_SIZE     = 16'h0020,
    parameter logic [15:0] SMEM_BASE     = 16'hA000,
    parameter logic [15:0] SMEM_SIZE     = 16'h4000,
    parameter logic [15:0] KMEM_BASE     = 16'h6A00,
    parameter logic [15:0] KMEM_SIZE     = 16'h0040,
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int unsigned DMA_CH        = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [15:0]           pc,
    input  logic                  data_en,
    input  logic                  data_wr,
    input  logic [15:0]           data_addr,
    input  logic                  irq,
    input  logic [16*DMA_CH-1:0]  dma_addr,
    input  logic [DMA_CH-1:0]     dma_en,
    output logic                  reset
`ifdef VRASED_CAUSE_LOG_EN
    ,
    output logic [7:0]            viol_cause,
    output logic [7:0]            viol_count
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ATTEST = 2'd1,
        KILL   = 2'd2
    } state_t;

    // Last legal instruction address of the attestation code; leaving from anywhere else is an abort.
    localparam logic [16:0] SMEM_LAST = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE} - 17'd2;

    // 17-bit compare keeps regions that end at 16'hFFFF from wrapping onto low addresses.
    function automatic logic in_rgn(input logic [15:0] a, input logic [15:0] base,
                                    input logic [15:0] size);
        logic [16:0] ax;
        logic [16:0] hi;
        ax = {1'b0, a};
        hi = {1'b0, base} + {1'b0, size} - 17'd1;
        return (ax >= {1'b0, base}) && (ax <= hi);
    endfunction

    state_t      state, state_nx;
    logic [15:0] pc_q;
    logic [7:0]  cause;
    logic        pc_smem;
    logic        dma_any, dma_key, dma_sdata;

    always_comb begin
        state_nx  = state;
        cause     = 8'h00;
        pc_smem   = in_rgn(pc, SMEM_BASE, SMEM_SIZE);
        dma_any   = 1'b0;
        dma_key   = 1'b0;
        dma_sdata = 1'b0;

        for (int k = 0; k < DMA_CH; k++) begin
            if (dma_en[k]) begin
                dma_any = 1'b1;
                if (in_rgn(dma_addr[16*k +: 16], KMEM_BASE, KMEM_SIZE))
                    dma_key = 1'b1;
                if (in_rgn(dma_addr[16*k +: 16], SDATA_BASE, SDATA_SIZE))
                    dma_sdata = 1'b1;
            end
        end

        case (state)
            RUN: begin
                if (pc_smem) begin
                    if (pc == SMEM_BASE)
                        state_nx = ATTEST;
                    else
                        cause[0] = 1'b1;
                end
                if (data_en && in_rgn(data_addr, SDATA_BASE, SDATA_SIZE))
                    cause[4] = 1'b1;
            end
            ATTEST: begin
                if (!pc_smem) begin
                    if ({1'b0, pc_q} == SMEM_LAST)
                        state_nx = RUN;
                    else
                        cause[1] = 1'b1;
                end
                if (irq && pc_smem)
                    cause[3] = 1'b1;
                if (data_wr && !in_rgn(data_addr, SDATA_BASE, SDATA_SIZE)
                            && !in_rgn(data_addr, HMAC_BASE, HMAC_SIZE))
                    cause[4] = 1'b1;
                cause[6] = dma_any;
            end
            KILL: begin
                if (pc == RESET_HANDLER)
                    state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase

        // Causes observed while already killed are deliberately dropped.
        if (state == RUN || state == ATTEST) begin
            cause[2] = data_en && in_rgn(data_addr, KMEM_BASE, KMEM_SIZE) && !pc_smem;
            cause[5] = dma_key;
            cause[7] = dma_sdata;
            if (cause != 8'h00)
                state_nx = KILL;
        end else begin
            cause = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            pc_q  <= 16'h0000;
            reset <= 1'b0;
        end else begin
            state <= state_nx;
            pc_q  <= pc;
            reset <= (state_nx == KILL);
        end
    end

`ifdef VRASED_CAUSE_LOG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            viol_cause <= 8'h00;
            viol_count <= 8'h00;
        end else if (state != KILL && state_nx == KILL) begin
            viol_cause <= viol_cause | cause;
            if (viol_count != 8'hFF)
                viol_count <= viol_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vrased_multi.sv
// tb/tb_vrased_multi.sv - vector table, corner sequences and random model check for vrased_multi
module tb_vrased_multi;

    localparam int DMA_CH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc;
    logic        data_en, data_wr, irq;
    logic [15:0] data_addr;
    logic [31:0] dma_addr;
    logic [1:0]  dma_en;
    logic        reset;
`ifdef VRASED_CAUSE_LOG_EN
    logic [7:0]  viol_cause, viol_count;
`endif

    always #5 clk = ~clk;

    vrased_multi #(.DMA_CH(DMA_CH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pc        (pc),
        .data_en   (data_en),
        .data_wr   (data_wr),
        .data_addr (data_addr),
        .irq       (irq),
        .dma_addr  (dma_addr),
        .dma_en    (dma_en),
        .reset     (reset)
`ifdef VRASED_CAUSE_LOG_EN
        ,
        .viol_cause(viol_cause),
        .viol_count(viol_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input logic [15:0] p);
        pc = p; data_en = 0; data_wr = 0; data_addr = 16'h0000; irq = 0;
        dma_en = 2'b00; dma_addr = 32'h0;
    endtask

    task automatic do_reset();
        quiet(16'h0100);
        reset_n = 0;
        cycle();
        cycle();
        reset_n = 1;
    endtask

    typedef struct {
        logic [15:0] pc;
        logic        den, dwr;
        logic [15:0] daddr;
        logic        irq;
        logic [1:0]  dmen;
        logic [15:0] a1, a0;
        logic        exp_r;
        logic [7:0]  exp_c;
        logic [7:0]  exp_n;
    } vec_t;

    function automatic vec_t mkv(logic [15:0] p, logic den, logic dwr, logic [15:0] da, logic iq,
                                 logic [1:0] me, logic [15:0] a1, logic [15:0] a0,
                                 logic r, logic [7:0] c, logic [7:0] n);
        vec_t v;
        v.pc = p; v.den = den; v.dwr = dwr; v.daddr = da; v.irq = iq;
        v.dmen = me; v.a1 = a1; v.a0 = a0; v.exp_r = r; v.exp_c = c; v.exp_n = n;
        return v;
    endfunction

    // Reference model state: 0 run, 1 attesting, 2 killed.
    int          m_mode;
    logic [15:0] m_pcq;
    logic        m_reset;
    logic [7:0]  m_cause;
    int          m_count;

    function automatic bit inr(int a, int base, int size);
        return (a >= base) && (a <= base + size - 1);
    endfunction

    task automatic model_step();
        int        nx;
        logic [7:0] c;
        bit        ps;
        nx = m_mode;
        c  = 8'h00;
        ps = inr(int'(pc), 'hA000, 'h4000);
        if (m_mode == 2) begin
            if (pc == 16'h0000) nx = 0;
        end else begin
            if (m_mode == 0 && ps) begin
                if (pc == 16'hA000) nx = 1; else c[0] = 1;
            end
            if (m_mode == 1 && !ps) begin
                if (m_pcq == 16'hDFFE) nx = 0; else c[1] = 1;
            end
            c[2] = data_en && inr(int'(data_addr), 'h6A00, 'h40) && !ps;
            c[3] = (m_mode == 1) && irq && ps;
            if (m_mode == 0)
                c[4] = data_en && inr(int'(data_addr), 'h0400, 'h0C00);
            else
                c[4] = data_wr && !inr(int'(data_addr), 'h0400, 'h0C00)
                               && !inr(int'(data_addr), 'h0230, 'h20);
            for (int ch = 0; ch < DMA_CH; ch++) begin
                if (dma_en[ch]) begin
                    int a;
                    a = int'(dma_addr[16*ch +: 16]);
                    if (inr(a, 'h6A00, 'h40))   c[5] = 1;
                    if (m_mode == 1)            c[6] = 1;
                    if (inr(a, 'h0400, 'h0C00)) c[7] = 1;
                end
            end
            if (c != 0) begin
                nx = 2;
                m_cause = m_cause | c;
                if (m_count < 255) m_count++;
            end
        end
        m_mode  = nx;
        m_pcq   = pc;
        m_reset = (nx == 2);
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return 16'($urandom_range('h69FE, 'h6A41));
            1: return 16'($urandom_range('h03FE, 'h1001));
            2: return 16'($urandom_range('h022E, 'h0251));
            default: return 16'($urandom_range(0, 'hFFFF));
        endcase
    endfunction

    initial begin
        vec_t tbl[$];
        logic any_high;

        reset_n = 1;
        quiet(16'h0100);
        reset_n = 0;
        #2;
        chk("reset_state_reset", {31'b0, reset}, 32'd0);
`ifdef VRASED_CAUSE_LOG_EN
        chk("reset_state_cause", {24'b0, viol_cause}, 32'h0);
        chk("reset_state_count", {24'b0, viol_count}, 32'h0);
`endif
        do_reset();

        //              pc       den dwr daddr    irq dmen a1       a0       r  cause  n
        tbl.push_back(mkv(16'h0100, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'h00, 8'd0));
        tbl.push_back(mkv(16'h0200, 1, 0, 16'h6A10, 0, 2'b10, 16'h6A00, 16'h0000, 1, 8'h24, 8'd1));
        tbl.push_back(mkv(16'h0300, 0, 0, 16'h0000, 1, 2'b01, 16'h0000, 16'h0500, 1, 8'h24, 8'd1));
        tbl.push_back(mkv(16'h0000, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'h24, 8'd1));
        tbl.push_back(mkv(16'h0100, 1, 0, 16'h0500, 0, 2'b00, 16'h0000, 16'h0000, 1, 8'h34, 8'd2));
        tbl.push_back(mkv(16'h0000, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'h34, 8'd2));
        tbl.push_back(mkv(16'hA000, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'h34, 8'd2));
        tbl.push_back(mkv(16'hA002, 1, 1, 16'h2000, 1, 2'b00, 16'h0000, 16'h0000, 1, 8'h3C, 8'd3));
        tbl.push_back(mkv(16'hA004, 1, 0, 16'h6A00, 0, 2'b11, 16'h6A00, 16'h0400, 1, 8'h3C, 8'd3));
        tbl.push_back(mkv(16'h0000, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'h3C, 8'd3));
        tbl.push_back(mkv(16'hA000, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'h3C, 8'd3));
        tbl.push_back(mkv(16'hA002, 1, 1, 16'h0230, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'h3C, 8'd3));
        tbl.push_back(mkv(16'hA004, 1, 1, 16'h0FFF, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'h3C, 8'd3));
        tbl.push_back(mkv(16'hA006, 1, 0, 16'h6A00, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'h3C, 8'd3));
        tbl.push_back(mkv(16'hDFFE, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'h3C, 8'd3));
        tbl.push_back(mkv(16'h0100, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'h3C, 8'd3));
        tbl.push_back(mkv(16'hA000, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'h3C, 8'd3));
        tbl.push_back(mkv(16'hA100, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'h3C, 8'd3));
        tbl.push_back(mkv(16'h0100, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 1, 8'h3E, 8'd4));
        tbl.push_back(mkv(16'h0000, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'h3E, 8'd4));
        tbl.push_back(mkv(16'hA000, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'h3E, 8'd4));
        tbl.push_back(mkv(16'hA002, 0, 0, 16'h0000, 0, 2'b01, 16'h0000, 16'h0000, 1, 8'h7E, 8'd5));
        tbl.push_back(mkv(16'h0000, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'h7E, 8'd5));
        tbl.push_back(mkv(16'h0100, 0, 0, 16'h0000, 0, 2'b10, 16'h0FFF, 16'h0000, 1, 8'hFE, 8'd6));
        tbl.push_back(mkv(16'h0000, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'hFE, 8'd6));
        tbl.push_back(mkv(16'h0100, 1, 0, 16'h1000, 0, 2'b11, 16'h03FF, 16'h6A40, 0, 8'hFE, 8'd6));
        tbl.push_back(mkv(16'hE000, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'hFE, 8'd6));
        tbl.push_back(mkv(16'h9FFE, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'hFE, 8'd6));
        tbl.push_back(mkv(16'hA000, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'hFE, 8'd6));
        tbl.push_back(mkv(16'hE000, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 1, 8'hFE, 8'd7));
        tbl.push_back(mkv(16'h0000, 0, 0, 16'h0000, 0, 2'b00, 16'h0000, 16'h0000, 0, 8'hFE, 8'd7));

        foreach (tbl[i]) begin
            pc = tbl[i].pc; data_en = tbl[i].den; data_wr = tbl[i].dwr;
            data_addr = tbl[i].daddr; irq = tbl[i].irq; dma_en = tbl[i].dmen;
            dma_addr = {tbl[i].a1, tbl[i].a0};
            cycle();
            chk($sformatf("tbl%0d_reset", i), {31'b0, reset}, {31'b0, tbl[i].exp_r});
`ifdef VRASED_CAUSE_LOG_EN
            chk($sformatf("tbl%0d_cause", i), {24'b0, viol_cause}, {24'b0, tbl[i].exp_c});
            chk($sformatf("tbl%0d_count", i), {24'b0, viol_count}, {24'b0, tbl[i].exp_n});
`endif
        end

        // Full legal attestation walk from entry to last instruction and out.
        do_reset();
        any_high = 0;
        quiet(16'h9FFE);
        cycle();
        any_high |= reset;
        for (int a = 'hA000; a <= 'hDFFE; a += 2) begin
            pc = 16'(a);
            cycle();
            any_high |= reset;
        end
        pc = 16'h0100;
        cycle();
        any_high |= reset;
        chk("walk_no_kill", {31'b0, any_high}, 32'd0);
        pc = 16'hA010;
        cycle();
        chk("walk_back_in_run", {31'b0, reset}, 32'd1);

        // Reset deasserted mid-attestation restarts in RUN.
        do_reset();
        quiet(16'hA000);
        cycle();
        pc = 16'hA002;
        reset_n = 0;
        #2;
        reset_n = 1;
        cycle();
        chk("restart_entry_reset", {31'b0, reset}, 32'd1);
`ifdef VRASED_CAUSE_LOG_EN
        chk("restart_entry_cause", {24'b0, viol_cause}, 32'h01);
`endif

        // Saturation of the kill counter, then async clear in KILL.
        do_reset();
        repeat (256) begin
            quiet(16'hA010);
            cycle();
            quiet(16'h0000);
            cycle();
        end
        quiet(16'hA010);
        cycle();
        chk("sat_kill_reset", {31'b0, reset}, 32'd1);
`ifdef VRASED_CAUSE_LOG_EN
        chk("sat_count", {24'b0, viol_count}, 32'hFF);
        chk("sat_cause", {24'b0, viol_cause}, 32'h01);
`endif
        #2;
        reset_n = 0;
        #1;
        chk("async_clear_reset", {31'b0, reset}, 32'd0);
`ifdef VRASED_CAUSE_LOG_EN
        chk("async_clear_cause", {24'b0, viol_cause}, 32'h00);
        chk("async_clear_count", {24'b0, viol_count}, 32'h00);
`endif
        cycle();
        reset_n = 1;

        // Randomized traffic against the behavioural model.
        do_reset();
        m_mode = 0; m_pcq = 16'h0000; m_reset = 0; m_cause = 8'h00; m_count = 0;
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 5))
                0: pc = 16'hA000;
                1: pc = 16'hDFFE;
                2: pc = 16'hA000 + 16'($urandom_range(0, 'h3FFF));
                3: pc = 16'($urandom_range('h0100, 'h9FFF));
                4: pc = 16'h0000;
                default: pc = 16'($urandom_range('hE000, 'hFFFF));
            endcase
            data_en   = ($urandom_range(0, 3) == 0);
            data_wr   = data_en && ($urandom_range(0, 1) == 1);
            data_addr = rand_addr();
            irq       = ($urandom_range(0, 7) == 0);
            dma_en    = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            dma_addr  = {rand_addr(), rand_addr()};
            model_step();
            cycle();
            chk($sformatf("rnd%0d_reset", n), {31'b0, reset}, {31'b0, m_reset});
`ifdef VRASED_CAUSE_LOG_EN
            chk($sformatf("rnd%0d_cause", n), {24'b0, viol_cause}, {24'b0, m_cause});
            chk($sformatf("rnd%0d_count", n), {24'b0, viol_count}, 32'(m_count));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
